// File: rtl/vm_pkg.sv
// Shared definitions for the change dispenser: coin codes, coin values and FSM states.
package vm_pkg;

  localparam logic [1:0] COIN_10 = 2'b00;
  localparam logic [1:0] COIN_5  = 2'b01;
  localparam logic [1:0] COIN_1  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_DONE
  } state_t;

  // Code 11 is never issued, so it maps to a value of zero.
  function automatic int unsigned coin_value(input logic [1:0] code);
    case (code)
      COIN_10: coin_value = 10;
      COIN_5:  coin_value = 5;
      COIN_1:  coin_value = 1;
      default: coin_value = 0;
    endcase
  endfunction

endpackage

// File: rtl/coin_tube.sv
// One coin tube inventory: saturating restock add plus single-coin decrement.
module coin_tube #(
  parameter int TUBE_W    = 4,
  parameter int TUBE_INIT = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              add,
  input  logic [TUBE_W-1:0] qty,
  input  logic              dec,
  output logic [TUBE_W-1:0] count
);

  localparam logic [TUBE_W:0] MAX = {1'b0, {TUBE_W{1'b1}}};

  logic [TUBE_W:0]   sum;
  logic [TUBE_W-1:0] sat;

  // Restock saturates first; a same-cycle dispense then takes one coin off the result.
  always_comb begin
    sum = {1'b0, count} + (add ? {1'b0, qty} : '0);
    sat = (sum > MAX) ? {TUBE_W{1'b1}} : sum[TUBE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= TUBE_W'(TUBE_INIT);
    end else if (dec && sat != '0) begin
      count <= sat - {{(TUBE_W-1){1'b0}}, 1'b1};
    end else begin
      count <= sat;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays a change balance greedily from 10/5/1 coin tubes, one coin per hopper handshake.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int BAL_W     = 6,
  parameter int TUBE_W    = 4,
  parameter int TUBE_INIT = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              change_req,
  input  logic [BAL_W-1:0]  change_amt,
  output logic              busy,
  output logic              coin_valid,
  input  logic              coin_ready,
  output logic [1:0]        coin_type,
  output logic              done,
  output logic              short,
  output logic [BAL_W-1:0]  shortfall,
  input  logic              restock,
  input  logic [1:0]        restock_type,
  input  logic [TUBE_W-1:0] restock_qty,
  output logic [TUBE_W-1:0] tube10_count,
  output logic [TUBE_W-1:0] tube5_count,
  output logic [TUBE_W-1:0] tube1_count,
  output state_t            state_dbg
);

  state_t             state, state_nx;
  logic [BAL_W-1:0]   remaining;
  logic [1:0]         sel_type;
  logic               sel_ok;
  logic               hs;

  // Hopper handshake: a coin transfers on any rising edge where coin_valid and
  // coin_ready are both high; coin_valid never drops and coin_type never changes
  // while a coin is offered and not yet taken.
  assign hs = coin_valid & coin_ready;

  coin_tube #(.TUBE_W(TUBE_W), .TUBE_INIT(TUBE_INIT)) u_tube10 (
    .clk(clk), .rst(rst),
    .add(restock && restock_type == COIN_10), .qty(restock_qty),
    .dec(hs && coin_type == COIN_10), .count(tube10_count)
  );
  coin_tube #(.TUBE_W(TUBE_W), .TUBE_INIT(TUBE_INIT)) u_tube5 (
    .clk(clk), .rst(rst),
    .add(restock && restock_type == COIN_5), .qty(restock_qty),
    .dec(hs && coin_type == COIN_5), .count(tube5_count)
  );
  coin_tube #(.TUBE_W(TUBE_W), .TUBE_INIT(TUBE_INIT)) u_tube1 (
    .clk(clk), .rst(rst),
    .add(restock && restock_type == COIN_1), .qty(restock_qty),
    .dec(hs && coin_type == COIN_1), .count(tube1_count)
  );

  // Greedy pick: largest coin that fits in the remainder and is in stock.
  always_comb begin
    sel_ok   = 1'b1;
    sel_type = COIN_10;
    if (remaining >= BAL_W'(coin_value(COIN_10)) && tube10_count != '0) begin
      sel_type = COIN_10;
    end else if (remaining >= BAL_W'(coin_value(COIN_5)) && tube5_count != '0) begin
      sel_type = COIN_5;
    end else if (remaining >= BAL_W'(coin_value(COIN_1)) && tube1_count != '0) begin
      sel_type = COIN_1;
    end else begin
      sel_ok = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (change_req) state_nx = ST_SELECT;
      ST_SELECT: state_nx = sel_ok ? ST_ISSUE : ST_DONE;
      ST_ISSUE:  if (coin_ready) state_nx = ST_SELECT;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      coin_type <= COIN_10;
    end else begin
      case (state)
        ST_IDLE:   if (change_req) remaining <= change_amt;
        ST_SELECT: if (sel_ok) coin_type <= sel_type;
        ST_ISSUE:  if (hs) remaining <= remaining - BAL_W'(coin_value(coin_type));
        default:   ;
      endcase
    end
  end

  // Whatever is left in DONE could not be paid from the tubes.
  assign busy       = (state != ST_IDLE);
  assign coin_valid = (state == ST_ISSUE);
  assign done       = (state == ST_DONE);
  assign short      = done && (remaining != '0);
  assign shortfall  = short ? remaining : '0;
  assign state_dbg  = state;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with a queue-based scoreboard per instance.
module tb_change_dispenser;
  import vm_pkg::*;

  localparam int W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       req_a, ready_a, restock_a;
  logic [5:0] amt_a;
  logic [1:0] rtype_a;
  logic [3:0] rqty_a;
  logic       busy_a, valid_a, done_a, short_a;
  logic [1:0] type_a;
  logic [5:0] sf_a;
  logic [3:0] t10_a, t5_a, t1_a;
  state_t     st_a;

  logic       req_b, ready_b, restock_b;
  logic [5:0] amt_b;
  logic [1:0] rtype_b;
  logic [3:0] rqty_b;
  logic       busy_b, valid_b, done_b, short_b;
  logic [1:0] type_b;
  logic [5:0] sf_b;
  logic [3:0] t10_b, t5_b, t1_b;
  state_t     st_b;

  change_dispenser #(.BAL_W(6), .TUBE_W(4), .TUBE_INIT(10)) dut_a (
    .clk(clk), .rst(rst), .change_req(req_a), .change_amt(amt_a),
    .busy(busy_a), .coin_valid(valid_a), .coin_ready(ready_a), .coin_type(type_a),
    .done(done_a), .short(short_a), .shortfall(sf_a),
    .restock(restock_a), .restock_type(rtype_a), .restock_qty(rqty_a),
    .tube10_count(t10_a), .tube5_count(t5_a), .tube1_count(t1_a), .state_dbg(st_a)
  );

  change_dispenser #(.BAL_W(6), .TUBE_W(4), .TUBE_INIT(1)) dut_b (
    .clk(clk), .rst(rst), .change_req(req_b), .change_amt(amt_b),
    .busy(busy_b), .coin_valid(valid_b), .coin_ready(ready_b), .coin_type(type_b),
    .done(done_b), .short(short_b), .shortfall(sf_b),
    .restock(restock_b), .restock_type(rtype_b), .restock_qty(rqty_b),
    .tube10_count(t10_b), .tube5_count(t5_b), .tube1_count(t1_b), .state_dbg(st_b)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [W-1:0] coin_item(input logic [1:0] t);
    coin_item = {1'b0, t, 7'd0};
  endfunction

  function automatic logic [W-1:0] done_item(input logic s, input logic [5:0] sf);
    done_item = {1'b1, 2'b00, s, sf};
  endfunction

  task automatic sb_a(input string name, input logic [W-1:0] obs);
    if (exp_a_q.size() == 0) begin
      n_chk++;
      $display("FAIL %s: unexpected output item %h, expected none", name, obs);
    end else begin
      chk(name, 32'(obs), 32'(exp_a_q.pop_front()));
    end
  endtask

  task automatic sb_b(input string name, input logic [W-1:0] obs);
    if (exp_b_q.size() == 0) begin
      n_chk++;
      $display("FAIL %s: unexpected output item %h, expected none", name, obs);
    end else begin
      chk(name, 32'(obs), 32'(exp_b_q.pop_front()));
    end
  endtask

  // Monitor: a coin is logged when valid & ready are seen, completion when done is seen.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_a && ready_a) sb_a("coin_a", {1'b0, type_a, 7'd0});
      if (done_a)             sb_a("done_a", {1'b1, 2'b00, short_a, sf_a});
      if (valid_b && ready_b) sb_b("coin_b", {1'b0, type_b, 7'd0});
      if (done_b)             sb_b("done_b", {1'b1, 2'b00, short_b, sf_b});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [5:0] amt);
    tick();
    req_a = 1'b1;
    amt_a = amt;
    tick();
    req_a = 1'b0;
  endtask

  task automatic send_b(input logic [5:0] amt);
    tick();
    req_b = 1'b1;
    amt_b = amt;
    tick();
    req_b = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid_a(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!valid_a && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!valid_a) begin
      n_chk++;
      $display("FAIL %s: timeout waiting for coin_valid", name);
    end
  endtask

  task automatic wait_done_a(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!done_a && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!done_a) begin
      n_chk++;
      $display("FAIL %s: timeout waiting for done", name);
    end
  endtask

  task automatic wait_done_b(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!done_b && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!done_b) begin
      n_chk++;
      $display("FAIL %s: timeout waiting for done", name);
    end
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    req_a = 0; amt_a = '0; ready_a = 0; restock_a = 0; rtype_a = '0; rqty_a = '0;
    req_b = 0; amt_b = '0; ready_b = 1; restock_b = 0; rtype_b = '0; rqty_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_t10", 32'(t10_a), 10);
    chk("rst_t5", 32'(t5_a), 10);
    chk("rst_t1", 32'(t1_a), 10);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_valid", 32'(valid_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_shortfall", 32'(sf_a), 0);
    chk("rst_type", 32'(type_a), 0);
    chk("rst_state", 32'(st_a), 32'(ST_IDLE));
    chk("rst_b_t10", 32'(t10_b), 1);

    // Short payout from single-coin tubes: 20 -> 10,5,1 then short by 4
    exp_b_q.push_back(coin_item(COIN_10));
    exp_b_q.push_back(coin_item(COIN_5));
    exp_b_q.push_back(coin_item(COIN_1));
    exp_b_q.push_back(done_item(1'b1, 6'd4));
    send_b(6'd20);
    wait_done_b("short_wait");
    chk("short_t10", 32'(t10_b), 0);
    chk("short_t5", 32'(t5_b), 0);
    chk("short_t1", 32'(t1_b), 0);

    // Greedy 27 -> 10,10,5,1,1 with ready held high
    tick();
    ready_a = 1'b1;
    exp_a_q.push_back(coin_item(COIN_10));
    exp_a_q.push_back(coin_item(COIN_10));
    exp_a_q.push_back(coin_item(COIN_5));
    exp_a_q.push_back(coin_item(COIN_1));
    exp_a_q.push_back(coin_item(COIN_1));
    exp_a_q.push_back(done_item(1'b0, 6'd0));
    send_a(6'd27);
    wait_done_a("greedy_wait");
    chk("greedy_t10", 32'(t10_a), 8);
    chk("greedy_t5", 32'(t5_a), 9);
    chk("greedy_t1", 32'(t1_a), 8);
    @(negedge clk);
    chk("greedy_busy_after", 32'(busy_a), 0);

    // Backpressure: coin held stable while ready is low
    do_reset();
    ready_a = 1'b0;
    exp_a_q.push_back(coin_item(COIN_5));
    exp_a_q.push_back(done_item(1'b0, 6'd0));
    send_a(6'd5);
    wait_valid_a("bp_valid");
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid_hold", 32'(valid_a), 1);
      chk("bp_type_hold", 32'(type_a), 32'(COIN_5));
      chk("bp_t5_hold", 32'(t5_a), 10);
      if (i < 2) @(negedge clk);
    end
    tick();
    ready_a = 1'b1;
    wait_done_a("bp_wait");
    chk("bp_t5_after", 32'(t5_a), 9);
    chk("bp_t10_after", 32'(t10_a), 10);

    // Overlapping request ignored; restock collides with a tube10 dispense
    do_reset();
    ready_a = 1'b0;
    exp_a_q.push_back(coin_item(COIN_10));
    exp_a_q.push_back(coin_item(COIN_10));
    exp_a_q.push_back(done_item(1'b0, 6'd0));
    send_a(6'd20);
    req_a = 1'b1;
    amt_a = 6'd7;
    tick();
    req_a = 1'b0;
    wait_valid_a("ovl_valid1");
    tick();
    ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
    wait_valid_a("ovl_valid2");
    chk("ovl_t10_before", 32'(t10_a), 9);
    tick();
    ready_a = 1'b1;
    restock_a = 1'b1;
    rtype_a = COIN_10;
    rqty_a = 4'd15;
    tick();
    restock_a = 1'b0;
    rqty_a = '0;
    @(negedge clk);
    chk("ovl_t10_collide", 32'(t10_a), 14);
    chk("ovl_t5", 32'(t5_a), 10);
    wait_done_a("ovl_wait");
    repeat (6) @(negedge clk);
    chk("ovl_not_queued", 32'(busy_a), 0);

    // Idle restock: tube1 +3, then an ignored code 11 strobe
    tick();
    restock_a = 1'b1; rtype_a = COIN_1; rqty_a = 4'd3;
    tick();
    rtype_a = 2'b11; rqty_a = 4'd5;
    tick();
    restock_a = 1'b0; rqty_a = '0;
    @(negedge clk);
    chk("rs_t1", 32'(t1_a), 13);
    chk("rs_t10_code11", 32'(t10_a), 14);
    chk("rs_t5_code11", 32'(t5_a), 10);

    // Abort: reset while the second coin is offered
    do_reset();
    ready_a = 1'b0;
    exp_a_q.push_back(coin_item(COIN_10));
    send_a(6'd15);
    wait_valid_a("abort_valid1");
    tick();
    ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
    wait_valid_a("abort_valid2");
    chk("abort_type", 32'(type_a), 32'(COIN_5));
    chk("abort_t10_before", 32'(t10_a), 9);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", 32'(valid_a), 0);
    chk("abort_state", 32'(st_a), 32'(ST_IDLE));
    chk("abort_t10", 32'(t10_a), 10);
    seen = 0;
    repeat (10) begin
      if (done_a) seen++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(seen), 0);

    chk("queue_a_empty", 32'(exp_a_q.size()), 0);
    chk("queue_b_empty", 32'(exp_b_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
